permute_slice_writer: RTL and testbench
=======================================

// Module: permute_slice_writer
//
// PURPOSE
//   Downstream stage of the 25-bit slice permute datapath. It takes each permuted 25-bit slice
//   (5x5 lane bits) over a valid/ready handshake and buffers it in a 2-entry FIFO. It then writes
//   the slices in arrival order to the result memory at sequential addresses 0..NUM_SLICES-1.
//   When the last write completes it pulses done and returns to idle, ready for the next start.
//
// PARAMETERS
//   W           25  slice width in bits (5x5 lane bits)
//   NUM_SLICES  64  slices per permutation run
//   ADDR_W      6   memory address width; must satisfy 2**ADDR_W >= NUM_SLICES
//
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous, active-high reset
//   start      in   1       begin a run; sampled only in IDLE
//   in_valid   in   1       upstream slice valid
//   in_data    in   W       permuted slice from the permute datapath output
//   in_ready   out  1       block accepts in_data this cycle
//   mem_wr     out  1       write request to result memory
//   mem_addr   out  ADDR_W  write address = slices written so far in this run
//   mem_data   out  W       write data = FIFO head
//   mem_ready  in   1       memory accepts the write this cycle
//   busy       out  1       high in RUN
//   done       out  1       one-cycle pulse after the final write
//
// BEHAVIOUR
//   Reset (rst=1 at a clock edge), from any state:
//   - FSM goes to IDLE; FIFO count, rd/wr pointers, rcv_cnt and wr_cnt all go to 0.
//   - in_ready, mem_wr, busy and done are 0; mem_addr is 0.
//   - An active run is abandoned. No writes occur in the reset cycle.
//   FSM states: IDLE, RUN, DONE.
//   - IDLE: in_ready=0, mem_wr=0. start=1 -> RUN; clears rcv_cnt, wr_cnt and the FIFO.
//   - RUN: busy=1. start is ignored.
//   - RUN -> DONE on the edge where the write with wr_cnt==NUM_SLICES-1 completes.
//   - DONE: lasts exactly one cycle with done=1, busy=0. Always goes to IDLE.
//   Accept (input) side:
//   - in_ready = RUN && fifo_count<2 && rcv_cnt<NUM_SLICES.
//   - push = in_valid && in_ready; each push increments rcv_cnt.
//   - in_valid outside RUN, or beyond NUM_SLICES slices, is not accepted (in_ready=0).
//   Write (output) side:
//   - mem_wr = RUN && fifo_count>0. mem_data = FIFO head. mem_addr = wr_cnt[ADDR_W-1:0].
//   - pop = mem_wr && mem_ready; each pop increments wr_cnt.
//   - Outputs hold stable while mem_wr=1 && mem_ready=0.
//   FIFO:
//   - 2 entries of W bits; pointers wrap modulo 2; count ranges 0..2.
//   - Simultaneous push and pop at count 1 leaves count at 1. Data order is preserved.
//   - Push and pop cannot coincide at count 0 (nothing to pop) or count 2 (in_ready=0).
//   Latency:
//   - A slice accepted at edge k drives mem_wr=1 from cycle k+1 at the earliest.
//   - Full throughput of 1 slice/cycle when mem_ready is held at 1.
//   Widths: rcv_cnt and wr_cnt are ADDR_W+1 bits, so the value NUM_SLICES is representable.
//   Data is never modified: mem_data equals the accepted in_data, bit-exact.
//
// TESTING
//   1. Streaming: start, in_valid=1 for 64 cycles (data=addr*3), mem_ready=1 ->
//      writes addr 0..63 with matching data, done pulse 1 cycle after the last write, then IDLE.
//   2. Backpressure: mem_ready=0 for cycles 2..9 ->
//      in_ready drops after 2 slices are buffered; mem_addr/mem_data hold; no slice lost or duplicated.
//   3. Excess input: in_valid stays 1 after 64 accepts ->
//      in_ready=0 from then on; exactly 64 writes; in_valid while IDLE is never accepted.
//   4. Simultaneous push/pop: count=1 with push and pop on the same edge -> count stays 1, order kept.
//   5. Reset mid-run: rst after 10 writes ->
//      next cycle mem_wr=0, busy=0, addr=0; a new start rewrites from addr 0.
//   6. Start while busy: pulse start in RUN -> ignored; counters are not cleared.

Source files
------------

// File: rtl/permute_slice_writer.sv
// permute_slice_writer: accepts permuted 25-bit slices over valid/ready,
// buffers them in a 2-entry FIFO and writes them in arrival order to the
// result memory at addresses 0..NUM_SLICES-1, then pulses done.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// exactly when valid and ready are both 1 in the cycle before that edge. The
// sender holds its payload stable while valid=1 and ready=0. Ready never
// depends on valid on the same side.
module permute_slice_writer #(
    parameter int W          = 25,
    parameter int NUM_SLICES = 64,
    parameter int ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [W-1:0]      in_data,
    output logic              in_ready,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [W-1:0]      mem_data,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state,
    output logic [1:0]        dbg_fifo_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] NUM_C  = (ADDR_W+1)'(NUM_SLICES);
    localparam logic [ADDR_W:0] LAST_C = (ADDR_W+1)'(NUM_SLICES - 1);

    state_t            state_q, state_d;
    logic [W-1:0]      fifo_q [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic [ADDR_W:0]   rcv_cnt_q, rcv_cnt_d;
    logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
    logic              push, pop;

    // Handshake decode, next state and counter updates.
    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        rcv_cnt_d = rcv_cnt_q;
        wr_cnt_d  = wr_cnt_q;

        // Outputs are forced low during reset so no write is issued in the reset cycle.
        in_ready = !rst && (state_q == RUN) && (count_q != 2'd2) && (rcv_cnt_q < NUM_C);
        mem_wr   = !rst && (state_q == RUN) && (count_q != 2'd0);
        busy     = !rst && (state_q == RUN);
        done     = !rst && (state_q == DONE);
        mem_addr = rst ? '0 : wr_cnt_q[ADDR_W-1:0];
        mem_data = fifo_q[rd_ptr_q];

        push = in_valid && in_ready;
        pop  = mem_wr && mem_ready;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    rd_ptr_d  = 1'b0;
                    wr_ptr_d  = 1'b0;
                    count_d   = 2'd0;
                    rcv_cnt_d = '0;
                    wr_cnt_d  = '0;
                end
            end
            RUN: begin
                if (push) begin
                    wr_ptr_d  = ~wr_ptr_q;
                    rcv_cnt_d = rcv_cnt_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_d = ~rd_ptr_q;
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == LAST_C) begin
                        state_d = DONE;
                    end
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + 2'd1;
                    2'b01:   count_d = count_q - 2'd1;
                    default: count_d = count_q;
                endcase
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            rcv_cnt_q <= '0;
            wr_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            rcv_cnt_q <= rcv_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    // FIFO storage; contents are only meaningful where count says so, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_q[wr_ptr_q] <= in_data;
        end
    end

    assign dbg_state      = state_q;
    assign dbg_fifo_count = count_q;

endmodule

// File: tb/tb_permute_slice_writer.sv
// Testbench for permute_slice_writer: a per-cycle vector table for the
// short handshake corner cases, plus hand-written streaming, backpressure
// and reset-mid-run sequences checked against an expected-data queue.
module tb_permute_slice_writer;

    localparam int W  = 25;
    localparam int N  = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, mem_ready;
    logic [W-1:0]  in_data;
    logic          in_ready, mem_wr, busy, done;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_data;
    logic [1:0]    dbg_state, dbg_fifo_count;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q[$];

    permute_slice_writer #(.W(W), .NUM_SLICES(N), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ready(mem_ready), .busy(busy), .done(done),
        .dbg_state(dbg_state), .dbg_fifo_count(dbg_fifo_count)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b0; in_data = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    typedef struct {
        logic          rst, start, vld;
        logic [W-1:0]  d;
        logic          mr;
        logic          e_rdy, e_wr;
        logic [AW-1:0] e_addr;
        logic [W-1:0]  e_data;
        logic          e_busy, e_done;
        logic [1:0]    e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic s, input logic v, input logic [W-1:0] d,
                                input logic mr, input logic er, input logic ew, input logic [AW-1:0] ea,
                                input logic [W-1:0] ed, input logic eb, input logic edn, input logic [1:0] ec);
        vec_t t;
        t.rst = r; t.start = s; t.vld = v; t.d = d; t.mr = mr;
        t.e_rdy = er; t.e_wr = ew; t.e_addr = ea; t.e_data = ed;
        t.e_busy = eb; t.e_done = edn; t.e_cnt = ec;
        return t;
    endfunction

    // Stream N slices (data = index*3) with mem_ready low for cycles bp_lo..bp_hi.
    task automatic run_stream(input int bp_lo, input int bp_hi);
        int acc = 0;
        int wrs = 0;
        int last_wr = -1;
        int done_c = -1;
        int done_n = 0;
        logic prev_stall = 1'b0;
        logic [AW-1:0] pa = '0;
        logic [W-1:0]  pd = '0;
        logic [AW-1:0] ea;
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(W'(i * 3));
        do_start();
        for (int c = 0; c < 100; c++) begin
            in_valid  = 1'b1;
            in_data   = W'(acc * 3);
            mem_ready = !(c >= bp_lo && c <= bp_hi);
            #1;
            if (prev_stall) begin
                check("hold_addr", 32'(mem_addr), 32'(pa));
                check("hold_data", 32'(mem_data), 32'(pd));
            end
            if (acc == N) check("excess_in_ready", 32'(in_ready), 32'd0);
            if (bp_lo == 2 && c == 3) check("bp_in_ready_drop", 32'(in_ready), 32'd0);
            if (in_valid && in_ready) acc++;
            if (mem_wr && mem_ready) begin
                ea = AW'(wrs);
                check("wr_addr", 32'(mem_addr), 32'(ea));
                if (exp_q.size() > 0) begin
                    check("wr_data", 32'(mem_data), 32'(exp_q.pop_front()));
                end else begin
                    tests++; fails++;
                    $display("FAIL extra_write: write %0d beyond expected %0d", wrs, N);
                end
                wrs++;
                last_wr = c;
            end
            prev_stall = mem_wr && !mem_ready;
            pa = mem_addr;
            pd = mem_data;
            if (done) begin
                done_n++;
                done_c = c;
                check("done_busy", 32'(busy), 32'd0);
            end else if (done_n > 0) begin
                check("idle_in_ready", 32'(in_ready), 32'd0);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        check("stream_writes", 32'(wrs), 32'(N));
        check("stream_accepts", 32'(acc), 32'(N));
        check("done_pulses", 32'(done_n), 32'd1);
        check("done_after_last", 32'(done_c), 32'(last_wr + 1));
        if (bp_lo < 0) check("done_cycle_full_rate", 32'(done_c), 32'd65);
        check("stream_end_state", 32'(dbg_state), 32'd0);
        check("stream_end_busy", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    vec_t vt[16];

    initial begin
        logic [W-1:0] d0, d1, d2, d3, d4, da;
        int acc;
        int wrs;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b0; in_data = '0;
        d0 = 25'h1555555; d1 = 25'h0AAAAAA; d2 = 25'h1FFFFFF;
        d3 = 25'h0000001; d4 = 25'h1234567; da = 25'h0ABCDEF;

        vt[0]  = mk(0,0,1,da,1, 0,0,0,0 ,0,0,0);
        vt[1]  = mk(0,1,0,0 ,0, 0,0,0,0 ,0,0,0);
        vt[2]  = mk(0,0,1,d0,0, 1,0,0,0 ,1,0,0);
        vt[3]  = mk(0,0,1,d1,0, 1,1,0,d0,1,0,1);
        vt[4]  = mk(0,0,1,d2,0, 0,1,0,d0,1,0,2);
        vt[5]  = mk(0,0,1,d2,0, 0,1,0,d0,1,0,2);
        vt[6]  = mk(0,0,1,d2,1, 0,1,0,d0,1,0,2);
        vt[7]  = mk(0,0,1,d2,1, 1,1,1,d1,1,0,1);
        vt[8]  = mk(0,0,1,d3,1, 1,1,2,d2,1,0,1);
        vt[9]  = mk(0,0,0,0 ,1, 1,1,3,d3,1,0,1);
        vt[10] = mk(0,0,0,0 ,1, 1,0,4,0 ,1,0,0);
        vt[11] = mk(0,1,0,0 ,0, 1,0,4,0 ,1,0,0);
        vt[12] = mk(0,0,1,d4,0, 1,0,4,0 ,1,0,0);
        vt[13] = mk(0,0,0,0 ,0, 1,1,4,d4,1,0,1);
        vt[14] = mk(1,0,0,0 ,1, 0,0,0,0 ,0,0,1);
        vt[15] = mk(0,0,1,da,1, 0,0,0,0 ,0,0,0);

        do_reset();
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_mem_wr", 32'(mem_wr), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_addr", 32'(mem_addr), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        check("reset_count", 32'(dbg_fifo_count), 32'd0);
        @(negedge clk);

        // Per-cycle vector table.
        for (int i = 0; i < 16; i++) begin
            rst = vt[i].rst; start = vt[i].start; in_valid = vt[i].vld;
            in_data = vt[i].d; mem_ready = vt[i].mr;
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vt[i].e_rdy));
            check($sformatf("vec%0d_mem_wr", i), 32'(mem_wr), 32'(vt[i].e_wr));
            check($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vt[i].e_addr));
            if (vt[i].e_wr) check($sformatf("vec%0d_data", i), 32'(mem_data), 32'(vt[i].e_data));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
            check($sformatf("vec%0d_done", i), 32'(done), 32'(vt[i].e_done));
            check($sformatf("vec%0d_count", i), 32'(dbg_fifo_count), 32'(vt[i].e_cnt));
            @(negedge clk);
        end
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;

        // Full-rate streaming, then the same with a backpressure window.
        run_stream(-1, -1);
        run_stream(2, 9);

        // Reset after 10 writes, then a fresh run restarts at address 0.
        do_reset();
        do_start();
        acc = 0;
        wrs = 0;
        for (int c = 0; c < 40 && wrs < 10; c++) begin
            in_valid = 1'b1; in_data = W'(acc * 3); mem_ready = 1'b1;
            #1;
            if (in_valid && in_ready) acc++;
            if (mem_wr && mem_ready) wrs++;
            @(negedge clk);
        end
        check("pre_reset_writes", 32'(wrs), 32'd10);
        rst = 1'b1;
        #1;
        check("rst_cycle_mem_wr", 32'(mem_wr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_mem_wr", 32'(mem_wr), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_addr", 32'(mem_addr), 32'd0);
        check("post_rst_in_ready", 32'(in_ready), 32'd0);
        check("post_rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        do_start();
        in_valid = 1'b1; in_data = 25'h00BEEF1; mem_ready = 1'b1;
        #1;
        check("restart_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("restart_mem_wr", 32'(mem_wr), 32'd1);
        check("restart_addr", 32'(mem_addr), 32'd0);
        check("restart_data", 32'(mem_data), 32'h00BEEF1);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
